// File: rtl/cbus_ch_rd_if.sv
// CBUS channel-buffer read bus between the channel-end reader (master) and the MB buffer (slave).
interface cbus_ch_rd_if;
    logic [6:0]  ch_buf_adr_h;
    logic        cbus_req_h;
    logic        cbus_ack_h;
    logic [0:35] cbus_d_re_h;
    logic [1:0]  cbus_par_re_h;

    modport master (
        output ch_buf_adr_h,
        output cbus_req_h,
        input  cbus_ack_h,
        input  cbus_d_re_h,
        input  cbus_par_re_h
    );

    modport slave (
        input  ch_buf_adr_h,
        input  cbus_req_h,
        output cbus_ack_h,
        output cbus_d_re_h,
        output cbus_par_re_h
    );
endinterface

// File: rtl/cbus_ch_rd.sv
// Channel-end CBUS reader: fetches a block of 36-bit words from the MB channel buffer into a FIFO.
// Optional half-word parity checking is enabled by defining CBUS_PAR_CHK_EN.
module cbus_ch_rd #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ACK_TIMEOUT = 31
) (
    input  logic              clk_ch_h,
    input  logic              mr_reset_h,
    input  logic              start_h,
    input  logic [6:0]        start_adr_h,
    input  logic [7:0]        word_cnt_h,
    input  logic              ch_reverse_h,
    input  logic              abort_h,
    output logic              busy_h,
    output logic              done_h,
    cbus_ch_rd_if.master      cbus,
    output logic [0:35]       dev_data_h,
    output logic              dev_valid_h,
    input  logic              dev_rdy_h,
    output logic              par_err_h,
    output logic              nxm_err_h
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DRAIN = 2'd2, ERR = 2'd3} state_e;

    state_e             state_q, state_d;
    logic [6:0]         adr_q, adr_d;
    logic [8:0]         wcnt_q, wcnt_d;
    logic               rev_q, rev_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               req_q, req_d;
    logic               valid_q, valid_d;
    logic               par_err_q, par_err_d;
    logic               nxm_err_q, nxm_err_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   fcnt_q, fcnt_d;
    logic [0:35]        mem_q [FIFO_DEPTH];
    logic [0:35]        mem_d [FIFO_DEPTH];

    logic push, pop, flush, par_bad, drain_empty;

    // Each half plus its parity bit must carry an odd number of ones.
`ifdef CBUS_PAR_CHK_EN
    assign par_bad = ~(^{cbus.cbus_d_re_h[0:17],  cbus.cbus_par_re_h[1]}) |
                     ~(^{cbus.cbus_d_re_h[18:35], cbus.cbus_par_re_h[0]});
`else
    logic unused_par;
    assign unused_par = ^cbus.cbus_par_re_h;
    assign par_bad    = 1'b0;
`endif

    assign pop         = valid_q & dev_rdy_h;
    assign drain_empty = ((fcnt_q - CNT_W'(pop)) == '0);

    // Transfer sequencing and error tracking.
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        wcnt_d    = wcnt_q;
        rev_d     = rev_q;
        tmo_d     = tmo_q;
        par_err_d = par_err_q;
        nxm_err_d = nxm_err_q;
        done_d    = 1'b0;
        push      = 1'b0;
        flush     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_h) begin
                    state_d   = REQ;
                    adr_d     = start_adr_h;
                    wcnt_d    = (word_cnt_h == 8'd0) ? 9'd256 : {1'b0, word_cnt_h};
                    rev_d     = ch_reverse_h;
                    tmo_d     = '0;
                    par_err_d = 1'b0;
                    nxm_err_d = 1'b0;
                end
            end
            REQ: begin
                if (req_q && cbus.cbus_ack_h) begin
                    push   = 1'b1;
                    adr_d  = rev_q ? (adr_q - 7'd1) : (adr_q + 7'd1);
                    wcnt_d = wcnt_q - 9'd1;
                    tmo_d  = '0;
                    if (par_bad) par_err_d = 1'b1;
                    if (wcnt_q == 9'd1) state_d = DRAIN;
                end else if (req_q) begin
                    if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                        nxm_err_d = 1'b1;
                        state_d   = ERR;
                        flush     = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_empty) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            ERR: begin
                flush   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort cancels silently; errors already latched are kept.
        if (abort_h && (state_q != IDLE)) begin
            state_d   = IDLE;
            flush     = 1'b1;
            push      = 1'b0;
            done_d    = 1'b0;
            par_err_d = par_err_q;
            nxm_err_d = nxm_err_q;
        end
    end

    // FIFO pointers/storage and the registered views derived from next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fcnt_d   = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = cbus.cbus_d_re_h;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            fcnt_d = fcnt_q + CNT_W'(push) - CNT_W'(pop);
        end
        req_d   = (state_d == REQ) && (fcnt_d < CNT_W'(FIFO_DEPTH));
        busy_d  = (state_d != IDLE);
        valid_d = (fcnt_d != '0);
    end

    always_ff @(posedge clk_ch_h) begin
        if (mr_reset_h) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            wcnt_q    <= '0;
            rev_q     <= 1'b0;
            tmo_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            nxm_err_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fcnt_q    <= '0;
            mem_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            wcnt_q    <= wcnt_d;
            rev_q     <= rev_d;
            tmo_q     <= tmo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            nxm_err_q <= nxm_err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fcnt_q    <= fcnt_d;
            mem_q     <= mem_d;
        end
    end

    assign busy_h            = busy_q;
    assign done_h            = done_q;
    assign cbus.ch_buf_adr_h = adr_q;
    assign cbus.cbus_req_h   = req_q;
    assign dev_data_h        = mem_q[rd_ptr_q];
    assign dev_valid_h       = valid_q;
    assign par_err_h         = par_err_q;
    assign nxm_err_h         = nxm_err_q;

endmodule

// File: tb/tb_cbus_ch_rd.sv
// Bench for cbus_ch_rd: queue-based reference model checked every cycle, plus directed block transfers.
module tb_cbus_ch_rd;
    localparam int DEPTH = 4;
    localparam int TMO   = 31;

    logic        clk = 1'b0;
    logic        mr_reset_h = 1'b1;
    logic        start_h = 1'b0;
    logic [6:0]  start_adr_h = '0;
    logic [7:0]  word_cnt_h = '0;
    logic        ch_reverse_h = 1'b0;
    logic        abort_h = 1'b0;
    logic        dev_rdy_h = 1'b0;
    logic        busy_h, done_h, dev_valid_h, par_err_h, nxm_err_h;
    logic [0:35] dev_data_h;

    cbus_ch_rd_if cbus();

    cbus_ch_rd #(.FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
        .clk_ch_h(clk), .mr_reset_h(mr_reset_h), .start_h(start_h),
        .start_adr_h(start_adr_h), .word_cnt_h(word_cnt_h), .ch_reverse_h(ch_reverse_h),
        .abort_h(abort_h), .busy_h(busy_h), .done_h(done_h), .cbus(cbus.master),
        .dev_data_h(dev_data_h), .dev_valid_h(dev_valid_h), .dev_rdy_h(dev_rdy_h),
        .par_err_h(par_err_h), .nxm_err_h(nxm_err_h)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // MB buffer contents and responder control
    logic [0:35] mb_mem [128];
    int          ack_budget = 1000000;
    int          bad_adr = -1;
    logic        req_prev = 1'b0;

    // Reference model state
    bit          m_ready = 0;
    int          m_phase = 0;          // 0 idle, 1 fetching, 2 draining, 3 error
    logic [0:35] m_q [$];
    int          m_adr = 0, m_left = 0, m_wait = 0;
    bit          m_rev = 0, m_par = 0, m_nxm = 0, m_done = 0;

    // Observation logs
    logic [6:0]  push_log [$];
    logic [0:35] pop_log [$];
    int          done_cnt = 0, noack = 0, last_pop_cyc = 0, done_cyc = 0;

    always @(posedge clk) cyc++;

    // MB responder: acks a request after it has been seen for one cycle.
    always @(negedge clk) begin
        #1;
        if (cbus.cbus_req_h && req_prev && !cbus.cbus_ack_h && ack_budget > 0) begin
            cbus.cbus_ack_h = 1'b1;
            ack_budget--;
        end else begin
            cbus.cbus_ack_h = 1'b0;
        end
        req_prev = cbus.cbus_req_h;
        cbus.cbus_d_re_h      = mb_mem[cbus.ch_buf_adr_h];
        cbus.cbus_par_re_h[1] = ~(^cbus.cbus_d_re_h[0:17]) ^ (int'(cbus.ch_buf_adr_h) == bad_adr);
        cbus.cbus_par_re_h[0] = ~(^cbus.cbus_d_re_h[18:35]);
    end

    // Logs what the next clock edge will see on the bus and device side.
    always @(negedge clk) begin
        #2;
        if (cbus.cbus_req_h && cbus.cbus_ack_h) begin
            push_log.push_back(cbus.ch_buf_adr_h);
            noack = 0;
        end else if (cbus.cbus_req_h && !nxm_err_h) begin
            noack++;
        end
        if (dev_valid_h && dev_rdy_h) begin
            pop_log.push_back(dev_data_h);
            last_pop_cyc = cyc;
        end
        if (done_h) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic bit half_bad(input logic [0:35] d, input logic [1:0] p);
        int l, r;
        l = $countones(d[0:17]) + int'(p[1]);
        r = $countones(d[18:35]) + int'(p[0]);
        return (l % 2 == 0) || (r % 2 == 0);
    endfunction

    // Reference model: advances once per clock from the inputs present at the edge.
    always @(posedge clk) begin
        bit room, take;
        if (mr_reset_h) begin
            m_ready = 1; m_phase = 0; m_q.delete(); m_adr = 0;
            m_par = 0; m_nxm = 0; m_done = 0; m_wait = 0;
        end else begin
            take   = (m_q.size() != 0) && dev_rdy_h;
            m_done = 0;
            if (m_phase != 0 && abort_h) begin
                m_phase = 0;
                m_q.delete();
            end else if (m_phase == 0) begin
                if (start_h) begin
                    m_phase = 1; m_adr = int'(start_adr_h);
                    m_left = (word_cnt_h == 8'd0) ? 256 : int'(word_cnt_h);
                    m_rev = ch_reverse_h; m_wait = 0; m_par = 0; m_nxm = 0;
                end
            end else if (m_phase == 1) begin
                room = (m_q.size() < DEPTH);
                if (take) void'(m_q.pop_front());
                if (room && cbus.cbus_ack_h) begin
                    m_q.push_back(cbus.cbus_d_re_h);
`ifdef CBUS_PAR_CHK_EN
                    if (half_bad(cbus.cbus_d_re_h, cbus.cbus_par_re_h)) m_par = 1;
`endif
                    m_adr  = (m_adr + (m_rev ? 127 : 1)) % 128;
                    m_left = m_left - 1;
                    m_wait = 0;
                    if (m_left == 0) m_phase = 2;
                end else if (room) begin
                    m_wait++;
                    if (m_wait == TMO) begin
                        m_nxm = 1; m_phase = 3; m_q.delete();
                    end
                end
            end else if (m_phase == 2) begin
                if (take) void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_done = 1; m_phase = 0;
                end
            end else begin
                m_done = 1; m_phase = 0;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(posedge clk) begin
        #2;
        if (m_ready) begin
            chk("cyc busy", 64'(busy_h), 64'(m_phase != 0));
            chk("cyc done", 64'(done_h), 64'(m_done));
            chk("cyc adr", 64'(cbus.ch_buf_adr_h), 64'(m_adr));
            chk("cyc req", 64'(cbus.cbus_req_h), 64'(m_phase == 1 && m_q.size() < DEPTH));
            chk("cyc valid", 64'(dev_valid_h), 64'(m_q.size() != 0));
            if (m_q.size() != 0) chk("cyc data", 64'(dev_data_h), 64'(m_q[0]));
            chk("cyc par_err", 64'(par_err_h), 64'(m_par));
            chk("cyc nxm_err", 64'(nxm_err_h), 64'(m_nxm));
        end
    end

    task automatic start(input logic [6:0] adr, input logic [7:0] cnt, input logic rev);
        @(negedge clk); #1;
        start_h = 1'b1; start_adr_h = adr; word_cnt_h = cnt; ch_reverse_h = rev;
        @(negedge clk); #1;
        start_h = 1'b0;
    endtask

    task automatic clear_logs();
        push_log.delete(); pop_log.delete(); done_cnt = 0; noack = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #3;
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < max_cyc) begin
            @(negedge clk); #3;
            n++;
        end
        chk({name, " done seen"}, 64'(done_cnt != d0), 64'(1));
        idle(3);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " busy"}, 64'(busy_h), 64'(0));
        chk({name, " done"}, 64'(done_h), 64'(0));
        chk({name, " adr"}, 64'(cbus.ch_buf_adr_h), 64'(0));
        chk({name, " req"}, 64'(cbus.cbus_req_h), 64'(0));
        chk({name, " valid"}, 64'(dev_valid_h), 64'(0));
        chk({name, " data"}, 64'(dev_data_h), 64'(0));
        chk({name, " par"}, 64'(par_err_h), 64'(0));
        chk({name, " nxm"}, 64'(nxm_err_h), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fwd_exp [4];
        int rev_exp [6];
        int n;
        logic [0:35] odd_word;
        fwd_exp = '{126, 127, 0, 1};
        rev_exp = '{1, 0, 127, 126, 125, 124};
        odd_word = 36'o123456654321;
        for (int i = 0; i < 128; i++) mb_mem[i] = 36'(i) * 36'h0_9E37_79B1 ^ 36'h5_A5A5_A5A5;
        cbus.cbus_ack_h = 1'b0; cbus.cbus_d_re_h = '0; cbus.cbus_par_re_h = '0;

        repeat (3) @(negedge clk);
        #1 mr_reset_h = 1'b0;
        #2 chk_all_zero("reset");

        // Forward block across the 127->0 wrap
        clear_logs(); dev_rdy_h = 1'b1;
        start(7'h7E, 8'd4, 1'b0);
        wait_done(100, "fwd");
        chk("fwd npush", 64'(push_log.size()), 64'(4));
        for (int i = 0; i < 4 && i < push_log.size(); i++) chk("fwd adr", 64'(push_log[i]), 64'(fwd_exp[i]));
        chk("fwd npop", 64'(pop_log.size()), 64'(4));
        for (int i = 0; i < 4 && i < pop_log.size(); i++) chk("fwd word", 64'(pop_log[i]), 64'(mb_mem[fwd_exp[i]]));
        chk("fwd done count", 64'(done_cnt), 64'(1));
        chk("fwd done after pop", 64'(done_cyc - last_pop_cyc), 64'(1));
        chk("fwd busy end", 64'(busy_h), 64'(0));

        // Reverse with back-pressure; a start while busy is ignored
        clear_logs(); dev_rdy_h = 1'b0;
        start(7'h01, 8'd6, 1'b1);
        idle(12);
        start(7'h33, 8'd2, 1'b0);
        idle(12);
        chk("rev npush stall", 64'(push_log.size()), 64'(4));
        chk("rev req low", 64'(cbus.cbus_req_h), 64'(0));
        chk("rev valid", 64'(dev_valid_h), 64'(1));
        @(negedge clk); #1 dev_rdy_h = 1'b1;
        wait_done(100, "rev");
        chk("rev npush", 64'(push_log.size()), 64'(6));
        for (int i = 0; i < 6 && i < push_log.size(); i++) chk("rev adr", 64'(push_log[i]), 64'(rev_exp[i]));
        chk("rev npop", 64'(pop_log.size()), 64'(6));
        for (int i = 0; i < 6 && i < pop_log.size(); i++) chk("rev word", 64'(pop_log[i]), 64'(mb_mem[rev_exp[i]]));
        chk("rev done count", 64'(done_cnt), 64'(1));

        // Bad left-half parity on the second of three words
        clear_logs(); mb_mem[7'h11] = odd_word; bad_adr = 'h11;
        start(7'h10, 8'd3, 1'b0);
        wait_done(100, "par");
`ifdef CBUS_PAR_CHK_EN
        chk("par flag", 64'(par_err_h), 64'(1));
`else
        chk("par flag", 64'(par_err_h), 64'(0));
`endif
        chk("par npop", 64'(pop_log.size()), 64'(3));
        if (pop_log.size() > 1) chk("par word2", 64'(pop_log[1]), 64'(odd_word));
        bad_adr = -1;
        clear_logs();
        start(7'h20, 8'd1, 1'b0);
        chk("par cleared", 64'(par_err_h), 64'(0));
        wait_done(100, "par2");

        // Ack timeout after the first word
        clear_logs(); ack_budget = 1;
        start(7'h30, 8'd2, 1'b0);
        wait_done(200, "tmo");
        chk("tmo cycles", 64'(noack), 64'(31));
        chk("tmo nxm", 64'(nxm_err_h), 64'(1));
        chk("tmo valid", 64'(dev_valid_h), 64'(0));
        chk("tmo done count", 64'(done_cnt), 64'(1));
        chk("tmo busy", 64'(busy_h), 64'(0));
        ack_budget = 1000000;

        // Abort with two words queued
        clear_logs(); dev_rdy_h = 1'b0;
        start(7'h40, 8'd8, 1'b0);
        n = 0;
        while (push_log.size() < 2 && n < 50) begin @(negedge clk); #3; n++; end
        chk("abort reached 2", 64'(push_log.size()), 64'(2));
        @(negedge clk); #1;
        chk("abort pre valid", 64'(dev_valid_h), 64'(1));
        abort_h = 1'b1;
        @(negedge clk); #1;
        abort_h = 1'b0;
        chk("abort valid", 64'(dev_valid_h), 64'(0));
        chk("abort busy", 64'(busy_h), 64'(0));
        idle(5);
        chk("abort no done", 64'(done_cnt), 64'(0));

        // Reset mid-transfer
        start(7'h50, 8'd8, 1'b0);
        idle(5);
        @(negedge clk); #1 mr_reset_h = 1'b1;
        @(negedge clk); #1;
        chk_all_zero("midreset");
        mr_reset_h = 1'b0;
        idle(2);

        // word_cnt of zero moves 256 words
        clear_logs(); dev_rdy_h = 1'b1;
        start(7'h00, 8'd0, 1'b0);
        wait_done(1500, "w256");
        chk("w256 npush", 64'(push_log.size()), 64'(256));
        chk("w256 npop", 64'(pop_log.size()), 64'(256));
        if (push_log.size() == 256) chk("w256 last adr", 64'(push_log[255]), 64'(7'h7F));
        chk("w256 adr end", 64'(cbus.ch_buf_adr_h), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
